// File: rtl/fpu_normalizer.sv
// fpu_normalizer: bit-serial normalizer producing {hidden, frac, G, R, S} for the rounder.
module fpu_normalizer #(
  parameter int BIAS = 127,
  parameter int MW   = 48
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic [9:0]    in_exp,
  input  logic [MW-1:0] in_mantissa,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          norm_sign,
  output logic [9:0]    norm_exp,
  output logic [26:0]   norm_mantissa
);
  if (BIAS < 1 || MW < 28) begin : g_bad_params
    $error("fpu_normalizer: BIAS must be positive and MW at least 28");
  end
  typedef enum logic [1:0] {IDLE, SHIFT, OUT} state_t;
  state_t             state_q;
  logic [MW-1:0]      m_q;
  logic signed [9:0]  e_q;
  logic               s_q, sticky_q, out_valid_q, norm_sign_q;
  logic [9:0]         norm_exp_q;
  logic [26:0]        norm_mantissa_q;
  logic               rsh, lsh;
  assign rsh = m_q[MW-1] | (e_q < 10'sd1);
  assign lsh = ~m_q[MW-2] & (e_q > 10'sd1);
  assign in_ready      = (state_q == IDLE) & ~rst;
  assign out_valid     = out_valid_q;
  assign norm_sign     = norm_sign_q;
  assign norm_exp      = norm_exp_q;
  assign norm_mantissa = norm_mantissa_q;
  // out_valid is raised one cycle after entering OUT, giving 2+N latency from accept
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      m_q             <= '0;
      e_q             <= '0;
      s_q             <= 1'b0;
      sticky_q        <= 1'b0;
      out_valid_q     <= 1'b0;
      norm_sign_q     <= 1'b0;
      norm_exp_q      <= '0;
      norm_mantissa_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          m_q      <= in_mantissa;
          e_q      <= $signed(in_exp);
          s_q      <= in_sign;
          sticky_q <= 1'b0;
          state_q  <= SHIFT;
        end
        SHIFT: if (m_q == '0) begin
          norm_sign_q     <= s_q;
          norm_exp_q      <= '0;
          norm_mantissa_q <= {26'b0, sticky_q};
          state_q         <= OUT;
        end else if (rsh) begin
          m_q      <= m_q >> 1;
          sticky_q <= sticky_q | m_q[0];
          e_q      <= e_q + 10'sd1;
        end else if (lsh) begin
          m_q <= m_q << 1;
          e_q <= e_q - 10'sd1;
        end else begin
          norm_sign_q     <= s_q;
          norm_exp_q      <= m_q[MW-2] ? e_q : 10'd0;
          norm_mantissa_q <= {m_q[MW-2 -: 26], sticky_q | (|m_q[MW-28:0])};
          state_q         <= OUT;
        end
        OUT: if (!out_valid_q) out_valid_q <= 1'b1;
        else if (out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_normalizer.sv
// tb_fpu_normalizer: random and directed operands checked against a closed-form normalization model.
module tb_fpu_normalizer;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_sign = 1'b0, out_ready = 1'b1;
  logic [9:0]  in_exp = '0;
  logic [47:0] in_mantissa = '0;
  logic        in_ready, out_valid, norm_sign;
  logic [9:0]  norm_exp;
  logic [26:0] norm_mantissa;
  int errs = 0, checks = 0, cyc = 0;

  typedef struct {logic sgn; logic [9:0] ex; logic [26:0] mt; int n; int acc;} res_t;
  res_t q[$];

  fpu_normalizer #(.BIAS(127), .MW(48)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_exp(in_exp), .in_mantissa(in_mantissa), .out_valid(out_valid), .out_ready(out_ready),
    .norm_sign(norm_sign), .norm_exp(norm_exp), .norm_mantissa(norm_mantissa)
  );

  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Closed form: pick the whole shift distance from the leading-one position and exponent.
  function automatic res_t model(input logic s, input logic [9:0] e10, input logic [47:0] m);
    res_t o;
    int e, msb, r, l;
    logic [47:0] sh;
    logic st;
    e = int'($signed(e10));
    msb = -1; r = 0; l = 0; st = 1'b0; sh = m;
    o.sgn = s; o.acc = 0;
    for (int i = 0; i < 48; i++) if (m[i]) msb = i;
    if (msb < 0) begin
      o.ex = '0; o.mt = '0; o.n = 0;
      return o;
    end
    if (m[47] || e < 1) begin
      r = (1 - e > 1) ? 1 - e : 1;
      if (r > msb) begin
        o.ex = '0; o.mt = 27'd1; o.n = msb + 1;
        return o;
      end
      sh = m >> r;
      st = |(m & ((48'd1 << r) - 48'd1));
      e = e + r;
    end else if (!m[46] && e > 1) begin
      l = (46 - msb < e - 1) ? 46 - msb : e - 1;
      sh = m << l;
      e = e - l;
    end
    o.mt = {sh[46:21], st | (|sh[20:0])};
    o.ex = sh[46] ? 10'(e) : 10'd0;
    o.n = r + l;
    return o;
  endfunction

  initial begin
    res_t r;
    logic prev_ov;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        prev_ov = 1'b0;
      end else begin
        if (out_valid) begin
          chk("in_ready_low_in_out", 64'(in_ready), 64'd0);
          if (q.size() == 0) chk("unexpected_out_valid", 64'(out_valid), 64'd0);
          else begin
            if (!prev_ov) chk("latency", 64'(cyc), 64'(q[0].acc + 2 + q[0].n));
            chk("norm_sign", 64'(norm_sign), 64'(q[0].sgn));
            chk("norm_exp", 64'(norm_exp), 64'(q[0].ex));
            chk("norm_mantissa", 64'(norm_mantissa), 64'(q[0].mt));
            if (out_ready) void'(q.pop_front());
          end
        end
        if (in_valid && in_ready) begin
          r = model(in_sign, in_exp, in_mantissa);
          r.acc = cyc + 1;
          q.push_back(r);
        end
        prev_ov = out_valid;
      end
    end
  end

  task automatic start(input logic s, input logic [9:0] e, input logic [47:0] m, input int bp);
    int t;
    t = 0;
    while (!in_ready && t < 500) begin
      @(posedge clk); #1; t++;
    end
    chk("in_ready_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_sign = s; in_exp = e; in_mantissa = m; out_ready = (bp == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_mantissa = {16'($urandom), 32'($urandom)};
  endtask

  task automatic op(input logic s, input logic [9:0] e, input logic [47:0] m, input int bp);
    int t;
    start(s, e, m, bp);
    t = 0;
    while (!out_valid && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (!out_valid) chk("out_valid_timeout", 64'(out_valid), 64'd1);
    repeat (bp) @(posedge clk);
    #1 out_ready = 1'b1;
    t = 0;
    while (out_valid && t < 10) begin
      @(posedge clk); #1; t++;
    end
    if (out_valid) chk("out_valid_drop_timeout", 64'(out_valid), 64'd0);
  endtask

  initial begin
    res_t p;
    #5000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1, "watchdog");
  end

  initial begin
    res_t p;
    p = model(1'b0, 10'd127, 48'd1 << 46);
    chk("pin_norm_mt", 64'(p.mt), 64'h4000000); chk("pin_norm_ex", 64'(p.ex), 64'd127); chk("pin_norm_n", 64'(p.n), 64'd0);
    p = model(1'b0, 10'd100, 48'h800000000001);
    chk("pin_ovf_mt", 64'(p.mt), 64'h4000001); chk("pin_ovf_ex", 64'(p.ex), 64'd101); chk("pin_ovf_n", 64'(p.n), 64'd1);
    p = model(1'b0, 10'd127, 48'd1 << 40);
    chk("pin_lz_mt", 64'(p.mt), 64'h4000000); chk("pin_lz_ex", 64'(p.ex), 64'd121); chk("pin_lz_n", 64'(p.n), 64'd6);
    p = model(1'b0, 10'h3FE, 48'd1 << 46);
    chk("pin_subr_mt", 64'(p.mt), 64'h0800000); chk("pin_subr_ex", 64'(p.ex), 64'd0); chk("pin_subr_n", 64'(p.n), 64'd3);
    p = model(1'b0, 10'd3, 48'd1 << 40);
    chk("pin_subl_mt", 64'(p.mt), 64'h0400000); chk("pin_subl_ex", 64'(p.ex), 64'd0); chk("pin_subl_n", 64'(p.n), 64'd2);
    p = model(1'b1, 10'd50, 48'd0);
    chk("pin_zero_mt", 64'(p.mt), 64'd0); chk("pin_zero_sgn", 64'(p.sgn), 64'd1);
    p = model(1'b0, 10'h3C4, 48'h5);
    chk("pin_flush_mt", 64'(p.mt), 64'd1); chk("pin_flush_n", 64'(p.n), 64'd3);

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_norm", {34'(norm_mantissa), 10'(norm_exp), 1'(norm_sign)}, 64'd0);
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    op(1'b0, 10'd127, 48'd1 << 46, 0);
    op(1'b0, 10'd100, 48'h800000000001, 0);
    op(1'b0, 10'd127, 48'd1 << 40, 0);
    op(1'b0, 10'h3FE, 48'd1 << 46, 0);
    op(1'b0, 10'd3, 48'd1 << 40, 0);
    op(1'b1, 10'd50, 48'd0, 5);
    op(1'b0, 10'h3C4, 48'h5, 2);
    op(1'b1, 10'd300, 48'hC00000000000, 0);

    start(1'b0, 10'd127, 48'd1 << 20, 0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready_after", 64'(in_ready), 64'd1);
    chk("midrst_norm", {34'(norm_mantissa), 10'(norm_exp), 1'(norm_sign)}, 64'd0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("midrst_discarded", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    for (int k = 0; k < 150; k++) begin
      logic [47:0] m;
      logic [9:0]  e;
      m = {16'($urandom), 32'($urandom)} >> $urandom_range(0, 47);
      if ($urandom_range(0, 9) == 0) m = '0;
      e = 10'($urandom_range(0, 360)) - 10'd60;
      op(1'($urandom_range(0, 1)), e, m, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0);
    end
    repeat (3) @(posedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/fpu_normalizer.md
Name: fpu_normalizer

Overview:
- Multi-cycle normalizer that feeds the rounding stage.
- Takes a raw sign/exponent/48-bit significand from the add/mul datapath and produces the normalized triple {norm_sign, norm_exp, norm_mantissa} the rounder consumes.
- norm_mantissa is 27 bits: bit 26 is the hidden one, bits 25:3 are the fraction, bit 2 is guard, bit 1 is round, bit 0 is sticky.
- Shifts one bit per cycle under an FSM. Handles significand overflow, leading zeros, subnormal denormalization and zero. Uses a valid/ready handshake on both sides.

Parameters:
- BIAS, 127, exponent bias; informational only, since the min-normal biased exponent is 1.
- MW, 48, raw significand width; binary point sits between bit MW-2 and bit MW-3.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input operand valid
- in_ready  out  1  block can accept; asserted only in IDLE and deasserted during reset
- in_sign  in  1  raw sign
- in_exp  in  10  raw biased exponent, two's complement signed
- in_mantissa  in  48  raw significand; bit 47 = overflow position, bit 46 = hidden-one position
- out_valid  out  1  normalized result valid
- out_ready  in  1  rounder accepts result
- norm_sign  out  1  result sign
- norm_exp  out  10  normalized biased exponent; 0 for subnormal or zero
- norm_mantissa  out  27  {hidden, frac[22:0], G, R, S}

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE, out_valid=0, norm_sign=0, norm_exp=0, norm_mantissa=0.
  - Internal m, e and sticky registers are cleared.
  - Any in-flight operation is discarded, from any state.
- States: IDLE, SHIFT, OUT.
- IDLE:
  - in_ready=1.
  - When in_valid&in_ready: load m<=in_mantissa, e<=in_exp, s<=in_sign, sticky<=0, then go to SHIFT.
- SHIFT: one action per cycle, evaluated in this priority order.
  1. m==0 → finish as zero: norm_exp=0, norm_mantissa={26'b0, sticky}.
  2. m[47]==1, or signed e<1 → right shift. m<=m>>1, sticky<=sticky|m[0], e<=e+1.
  3. m[46]==0 and signed e>1 → left shift. m<=m<<1, e<=e-1.
  4. Otherwise → finish.
- Finish:
  - Register outputs and go to OUT.
  - norm_mantissa[26:1]=m[46:21].
  - norm_mantissa[0]=sticky | (|m[20:0]).
  - norm_exp = m[46] ? e : 10'd0. Hidden bit 0 at e=1 means subnormal.
  - norm_sign=s. Sign is preserved for zero.
- OUT:
  - out_valid=1. Outputs are held stable while out_ready=0.
  - out_valid&out_ready → out_valid<=0, go to IDLE.
  - in_ready=0; there is no overlap of operations.
- Latency:
  - out_valid rises 2+N cycles after the accept edge, where N = number of shift cycles.
  - An already-normalized operand takes 2 cycles.
  - The m==0 early exit bounds right-shift loops for very negative e.
- Arithmetic:
  - e is 10-bit two's complement and all comparisons are signed.
  - No saturation. Exponent overflow (e≥255) passes through unchanged to the rounder/exception logic.
  - Left shift never occurs while m[47]=1.
- Simultaneous events:
  - rst wins over every handshake.
  - in_valid is ignored outside IDLE.

Test Plan:
- Normalized input: in_mantissa=1<<46, in_exp=127, sign 0, out_ready=1 → out_valid at accept+2. norm_mantissa=27'h4000000, norm_exp=127.
- Overflow with sticky: in_mantissa=48'h800000000001, in_exp=100 → one right shift. norm_mantissa=27'h4000001, norm_exp=101, out_valid at accept+3.
- Leading zeros: in_mantissa=1<<40, in_exp=127 → 6 left shifts. norm_mantissa=27'h4000000, norm_exp=121, out_valid at accept+8.
- Subnormal, right: in_mantissa=1<<46, in_exp=10'h3FE (−2) → 3 right shifts. norm_mantissa=27'h0800000, norm_exp=0.
- Subnormal, left stop: in_mantissa=1<<40, in_exp=3 → 2 left shifts, then stop at e=1. norm_mantissa=27'h0400000, norm_exp=0.
- Zero, backpressure, reset:
  - in_mantissa=0, in_exp=50, sign 1 → norm_mantissa=0, norm_exp=0, norm_sign=1.
  - Hold out_ready=0 for 5 cycles → outputs stable and in_ready=0.
  - Assert rst mid-SHIFT → next cycle out_valid=0, in_ready=1 after rst drops.
